// File: rtl/bin2bcd_ctrl_if.sv
// Bus-side handshake and result signals of the binary-to-BCD sequencer.
interface bin2bcd_ctrl_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  ready;
    logic                  busy;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic                  done;

    modport master (
        output start, bin_in,
        input  ready, busy, bcd_out, overflow, done
    );

    modport slave (
        input  start, bin_in,
        output ready, busy, bcd_out, overflow, done
    );
endinterface

// File: rtl/bin2bcd_ctrl.sv
// Sequencer for a serial binary-to-BCD digit-cell chain: feeds the word MSB
// first with an init strobe, then registers the packed BCD result and overflow.
module bin2bcd_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    bin2bcd_ctrl_if.slave       bus,
    output logic                shift_init,
    output logic                serial_out,
    input  logic [4*DIGITS-1:0] bcd_chain,
    input  logic                top_cout
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               done_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; chain strobes are decoded straight from registers
    always_comb begin
        state_nxt  = state;
        shift_init = 1'b0;
        serial_out = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_init = (cnt == '0);
                serial_out = shreg[WIDTH-1];
                if (cnt == CNT_LAST) state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter, overflow accumulator and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.bin_in;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                    ovf_acc <= ovf_acc | top_cout;
                end
                CAPTURE: begin
                    bcd_q  <= bcd_chain;
                    ovf_q  <= ovf_acc;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Self-checking bench for bin2bcd_ctrl: two instances (3 and 2 digits) each
// driving a behavioural shift/double digit-cell chain, scoreboard on done.
module tb_bin2bcd_ctrl;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cyc;

    bin2bcd_ctrl_if #(.WIDTH(WIDTH), .DIGITS(3)) bus3 ();
    bin2bcd_ctrl_if #(.WIDTH(WIDTH), .DIGITS(2)) bus2 ();

    logic        init3, ser3, tc3;
    logic        init2, ser2, tc2;
    logic [11:0] chain3;
    logic [11:0] chain2;

    bin2bcd_ctrl #(.WIDTH(WIDTH), .DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .shift_init(init3), .serial_out(ser3),
        .bcd_chain(chain3), .top_cout(tc3)
    );

    bin2bcd_ctrl #(.WIDTH(WIDTH), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .shift_init(init2), .serial_out(ser2),
        .bcd_chain(chain2[7:0]), .top_cout(tc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One digit-cell step for a chain of n cells: add 3 if >= 5, shift in carry
    function automatic logic [11:0] cell_step(input logic [11:0] c, input logic din,
                                              input logic init, input int n);
        logic [11:0] r;
        logic        carry;
        logic [3:0]  dg;
        logic [3:0]  adj;
        r     = '0;
        carry = din;
        for (int k = 0; k < n; k++) begin
            dg  = c[4*k +: 4];
            adj = (dg >= 4'd5) ? dg + 4'd3 : dg;
            r[4*k +: 4] = init ? {3'b000, carry} : {adj[2:0], carry};
            carry = !init && (dg >= 4'd5);
        end
        return r;
    endfunction

    // Expected {overflow, BCD digits} of v truncated to n digits
    function automatic logic [12:0] exp_of(input int v, input int n);
        logic [12:0] e;
        int          r;
        e = '0;
        r = v;
        for (int k = 0; k < n; k++) begin
            e[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e[12] = (r != 0);
        return e;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain3 <= '0;
            chain2 <= '0;
        end else begin
            chain3 <= cell_step(chain3, ser3, init3, 3);
            chain2 <= cell_step(chain2, ser2, init2, 2);
        end
    end

    assign tc3 = !init3 && (chain3[11:8] >= 4'd5);
    assign tc2 = !init2 && (chain2[7:4]  >= 4'd5);

    logic [12:0] q3[$];
    logic [12:0] q2[$];
    int done_cnt3, init_cnt3, last_done3, prev_done3;

    // Scoreboard for the 3-digit instance
    always @(negedge clk) begin
        logic [12:0] e;
        if (reset && init3) init_cnt3++;
        if (reset && bus3.done) begin
            done_cnt3++;
            prev_done3 = last_done3;
            last_done3 = cyc;
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done3: got bcd=%h, required no done", bus3.bcd_out);
            end else begin
                e = q3.pop_front();
                if (bus3.bcd_out !== e[11:0]) begin
                    errors++;
                    $display("FAIL bcd3: got %h, required %h", bus3.bcd_out, e[11:0]);
                end
                checks++;
                if (bus3.overflow !== e[12]) begin
                    errors++;
                    $display("FAIL ovf3: got %b, required %b", bus3.overflow, e[12]);
                end
            end
        end
    end

    // Scoreboard for the 2-digit instance
    always @(negedge clk) begin
        logic [12:0] e;
        if (reset && bus2.done) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done2: got bcd=%h, required no done", bus2.bcd_out);
            end else begin
                e = q2.pop_front();
                if (bus2.bcd_out !== e[7:0]) begin
                    errors++;
                    $display("FAIL bcd2: got %h, required %h", bus2.bcd_out, e[7:0]);
                end
                checks++;
                if (bus2.overflow !== e[12]) begin
                    errors++;
                    $display("FAIL ovf2: got %b, required %b", bus2.overflow, e[12]);
                end
            end
        end
    end

    task automatic go3(input int v);
        for (int i = 0; i < 50 && !bus3.ready; i++) begin
            @(posedge clk); #1;
        end
        bus3.start  = 1'b1;
        bus3.bin_in = 8'(v);
        q3.push_back(exp_of(v, 3));
        @(posedge clk); #1;
        bus3.start = 1'b0;
    endtask

    task automatic go2(input int v);
        for (int i = 0; i < 50 && !bus2.ready; i++) begin
            @(posedge clk); #1;
        end
        bus2.start  = 1'b1;
        bus2.bin_in = 8'(v);
        q2.push_back(exp_of(v, 2));
        @(posedge clk); #1;
        bus2.start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (q3.size() != 0 || q2.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (q3.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL timeout_%s: %0d results outstanding, required 0", name, q3.size() + q2.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus3.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", bus3.ready); end
        checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", bus3.busy); end
        checks++; if ({init3, ser3} !== 2'b00) begin errors++; $display("FAIL rst_chain_strobes: got %b, required 00", {init3, ser3}); end
        checks++; if ({bus3.done, bus3.overflow} !== 2'b00) begin errors++; $display("FAIL rst_done_ovf: got %b, required 00", {bus3.done, bus3.overflow}); end
        checks++; if (bus3.bcd_out !== 12'h000) begin errors++; $display("FAIL rst_bcd: got %h, required 000", bus3.bcd_out); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_latency();
        go3(255);
        repeat (WIDTH) @(posedge clk);
        #1;
        checks++; if (bus3.done !== 1'b0) begin errors++; $display("FAIL early_done: got %b, required 0", bus3.done); end
        @(posedge clk); #1;
        checks++; if (bus3.done !== 1'b1) begin errors++; $display("FAIL latency_done: got %b, required 1", bus3.done); end
        drain("latency");
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus3.bcd_out !== 12'h255) begin errors++; $display("FAIL hold_bcd: got %h, required 255", bus3.bcd_out); end
        checks++; if (bus3.done !== 1'b0) begin errors++; $display("FAIL done_width: got %b, required 0", bus3.done); end
    endtask

    task automatic test_values();
        int vals[3] = '{0, 99, 100};
        int i0;
        foreach (vals[k]) begin
            i0 = init_cnt3;
            go3(vals[k]);
            drain("values");
            checks++;
            if (init_cnt3 - i0 != 1) begin
                errors++;
                $display("FAIL init_pulses: got %0d, required 1", init_cnt3 - i0);
            end
        end
    endtask

    task automatic test_overflow();
        go2(200);
        drain("ovf200");
        go2(99);
        drain("ovf99");
    endtask

    task automatic test_start_busy();
        int d0;
        d0 = done_cnt3;
        go3(42);
        repeat (2) @(posedge clk);
        #1;
        bus3.start  = 1'b1;
        bus3.bin_in = 8'd7;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        drain("busy");
        repeat (15) @(posedge clk);
        #1;
        checks++; if (done_cnt3 - d0 != 1) begin errors++; $display("FAIL busy_done_count: got %0d, required 1", done_cnt3 - d0); end
        checks++; if (bus3.bcd_out !== 12'h042) begin errors++; $display("FAIL busy_bcd: got %h, required 042", bus3.bcd_out); end
    endtask

    task automatic test_mid_reset();
        go3(77);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        q3.delete();
        checks++; if ({bus3.ready, bus3.busy} !== 2'b10) begin errors++; $display("FAIL mid_rst_ready_busy: got %b, required 10", {bus3.ready, bus3.busy}); end
        checks++; if ({init3, ser3, bus3.done, bus3.overflow} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: got %b, required 0000", {init3, ser3, bus3.done, bus3.overflow}); end
        checks++; if (bus3.bcd_out !== 12'h000) begin errors++; $display("FAIL mid_rst_bcd: got %h, required 000", bus3.bcd_out); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        go3(123);
        drain("after_reset");
    endtask

    task automatic test_back_to_back();
        int  d0;
        bit  seen;
        d0 = done_cnt3;
        bus3.start  = 1'b1;
        bus3.bin_in = 8'd150;
        q3.push_back(exp_of(150, 3));
        @(posedge clk); #1;
        bus3.bin_in = 8'd151;
        q3.push_back(exp_of(151, 3));
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus3.done;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_first_done: got 0, required 1 within 40 cycles"); end
        @(posedge clk); #1;
        bus3.start = 1'b0;
        drain("b2b");
        checks++; if (done_cnt3 - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d, required 2", done_cnt3 - d0); end
        checks++; if (last_done3 - prev_done3 != WIDTH + 2) begin errors++; $display("FAIL b2b_spacing: got %0d, required %0d", last_done3 - prev_done3, WIDTH + 2); end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        done_cnt3 = 0; init_cnt3 = 0; last_done3 = 0; prev_done3 = 0;
        bus3.start = 1'b0; bus3.bin_in = '0;
        bus2.start = 1'b0; bus2.bin_in = '0;
        test_reset();
        test_latency();
        test_values();
        test_overflow();
        test_start_busy();
        test_mid_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog");
    end
endmodule
